// File: rtl/pool_layer_sched.sv
// rtl/pool_layer_sched.sv - per-layer conv + 2x2 max-pool map sequencer
// Optional watchdog and ERR state are built when POOL_SCHED_TIMEOUT_EN is defined.
module pool_layer_sched #(
  parameter int NUM_MAPS    = 6,
  parameter int MAP_W       = 3,
  parameter int DRAIN_CYC   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_conv_done,
  input  logic             i_pool_done,
  output logic             o_conv_start,
  output logic [1:0]       o_cal_wait,
  output logic [MAP_W-1:0] o_map_idx,
  output logic             o_busy,
  output logic             o_layer_done,
  output logic             o_err
);
  typedef enum logic [2:0] {
    S_IDLE, S_CONV_GO, S_CONV_WAIT, S_POOL, S_DRAIN, S_FIN, S_ERR
  } state_t;

  localparam int DC_W = $clog2(DRAIN_CYC + 1);
  localparam logic [DC_W-1:0]  DRAIN_LAST = DC_W'(DRAIN_CYC - 1);
  localparam logic [MAP_W-1:0] LAST_MAP   = MAP_W'(NUM_MAPS - 1);

  state_t           r_state, w_state_nxt;
  logic             r_conv_seen, r_pool_armed;
  logic [DC_W-1:0]  r_drain_cnt;
  logic [MAP_W-1:0] r_map_idx, w_map_nxt;
  logic             r_conv_start, r_busy, r_layer_done, r_err;
  logic [1:0]       r_cal_wait, w_cal_wait;
  logic             w_conv_start, w_busy, w_layer_done, w_err;
  logic             w_timeout, w_start_ok;

`ifdef POOL_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_start_blk;

  assign w_timeout  = (r_state == S_CONV_WAIT || r_state == S_POOL) && (r_wd_cnt == WD_LAST);
  assign w_start_ok = i_start && !r_start_blk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt    <= '0;
      r_start_blk <= 1'b0;
    end else begin
      if (w_state_nxt != r_state)
        r_wd_cnt <= '0;
      else if (r_state == S_CONV_WAIT || r_state == S_POOL)
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      // a start that clears ERR must be released before it can launch a layer
      if (r_state == S_ERR && w_state_nxt == S_IDLE && i_start)
        r_start_blk <= 1'b1;
      else if (!i_start)
        r_start_blk <= 1'b0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
  assign w_timeout        = 1'b0;
  assign w_start_ok       = i_start;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_map_idx    <= '0;
      r_conv_start <= 1'b0;
      r_cal_wait   <= 2'b00;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_map_idx    <= w_map_nxt;
      r_conv_start <= w_conv_start;
      r_cal_wait   <= w_cal_wait;
      r_busy       <= w_busy;
      r_layer_done <= w_layer_done;
      r_err        <= w_err;
    end
  end

  // conv_done may land during CONV_GO; pool_done must be seen low in POOL before it counts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_conv_seen  <= 1'b0;
      r_pool_armed <= 1'b0;
      r_drain_cnt  <= '0;
    end else begin
      r_conv_seen  <= (r_state == S_CONV_GO) && i_conv_done;
      r_pool_armed <= (r_state == S_POOL) && (w_state_nxt == S_POOL) &&
                      (r_pool_armed || !i_pool_done);
      if (r_state == S_DRAIN && w_state_nxt == S_DRAIN)
        r_drain_cnt <= (r_drain_cnt == DRAIN_LAST) ? r_drain_cnt : r_drain_cnt + DC_W'(1);
      else
        r_drain_cnt <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (w_start_ok) w_state_nxt = S_CONV_GO;
        S_CONV_GO:   w_state_nxt = S_CONV_WAIT;
        S_CONV_WAIT: begin
          if (i_conv_done || r_conv_seen) w_state_nxt = S_POOL;
          else if (w_timeout)             w_state_nxt = S_ERR;
        end
        S_POOL: begin
          if (r_pool_armed && i_pool_done) w_state_nxt = S_DRAIN;
          else if (w_timeout)              w_state_nxt = S_ERR;
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST && !i_pool_done)
            w_state_nxt = (r_map_idx == LAST_MAP) ? S_FIN : S_CONV_GO;
        end
        S_FIN:   w_state_nxt = S_IDLE;
        S_ERR:   if (i_start) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they register alongside it
  always_comb begin
    w_map_nxt = r_map_idx;
    if (w_state_nxt == S_IDLE)
      w_map_nxt = '0;
    else if (r_state == S_DRAIN && w_state_nxt == S_CONV_GO)
      w_map_nxt = r_map_idx + MAP_W'(1);
    w_conv_start = (w_state_nxt == S_CONV_GO);
    w_busy       = (w_state_nxt != S_IDLE);
    w_layer_done = (w_state_nxt == S_FIN);
    w_err        = (w_state_nxt == S_ERR);
    case (w_state_nxt)
      S_CONV_GO, S_CONV_WAIT: w_cal_wait = 2'b01;
      S_POOL:                 w_cal_wait = 2'b11;
      default:                w_cal_wait = 2'b00;
    endcase
  end

  assign o_conv_start = r_conv_start;
  assign o_cal_wait   = r_cal_wait;
  assign o_map_idx    = r_map_idx;
  assign o_busy       = r_busy;
  assign o_layer_done = r_layer_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_pool_layer_sched.sv
// tb/tb_pool_layer_sched.sv - directed self-checking bench for pool_layer_sched
// Watchdog scenario follows POOL_SCHED_TIMEOUT_EN.
module tb_pool_layer_sched;
  localparam int MAP_W = 3;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic             i_conv_done = 1'b0;
  logic             i_pool_done = 1'b0;
  logic             o_conv_start;
  logic [1:0]       o_cal_wait;
  logic [MAP_W-1:0] o_map_idx;
  logic             o_busy;
  logic             o_layer_done;
  logic             o_err;

  int n_pass = 0;
  int n_total = 0;

  int cyc, conv_cd, pool_cd, hold_left, hold_extra;
  int n_cs, n_ld, min_gap, max_gap, gap, idx_bad, lat_bad;
  int first_cs_cyc, ld_cyc, pdlow_cyc, last_delta;
  bit in_pool, prev_cd;

  pool_layer_sched #(
    .NUM_MAPS(6), .MAP_W(MAP_W), .DRAIN_CYC(4), .TIMEOUT_CYC(64)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_conv_done(i_conv_done), .i_pool_done(i_pool_done),
    .o_conv_start(o_conv_start), .o_cal_wait(o_cal_wait), .o_map_idx(o_map_idx),
    .o_busy(o_busy), .o_layer_done(o_layer_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic resp_clear();
    cyc = 0; conv_cd = -1; pool_cd = -1; hold_left = -1;
    n_cs = 0; n_ld = 0; min_gap = 1000; max_gap = 0; gap = 0; idx_bad = 0; lat_bad = 0;
    first_cs_cyc = -1; ld_cyc = -1; pdlow_cyc = -1; last_delta = -1;
    in_pool = 0; prev_cd = 0;
    i_conv_done = 0; i_pool_done = 0; i_start = 0; i_abort = 0;
  endtask

  task automatic kick();
    resp_clear();
    @(negedge clk);
    i_start = 1;
  endtask

  // conv/pool responder: conv_done 20 cycles after conv_start, pool_done 30 after cal_wait=11
  task automatic resp_cycle();
    @(negedge clk);
    cyc++;
    i_start = 0;
    if (prev_cd && o_cal_wait !== 2'b11) lat_bad++;
    prev_cd = 0;
    i_conv_done = 0;
    if (conv_cd > 0) begin
      conv_cd--;
      if (conv_cd == 0) begin i_conv_done = 1; prev_cd = 1; conv_cd = -1; end
    end
    if (o_conv_start === 1'b1) begin
      if (o_map_idx !== 3'(n_cs)) idx_bad++;
      if (n_cs == 0) first_cs_cyc = cyc;
      else begin
        if (gap < min_gap) min_gap = gap;
        if (gap > max_gap) max_gap = gap;
        last_delta = cyc - pdlow_cyc;
      end
      n_cs++;
      conv_cd = 20;
    end
    if (o_cal_wait === 2'b00 && o_busy === 1'b1) gap++; else gap = 0;
    if (o_layer_done === 1'b1) begin n_ld++; ld_cyc = cyc; end
    if (o_cal_wait === 2'b11) begin
      if (!in_pool) begin in_pool = 1; pool_cd = 30; end
      else if (pool_cd > 0) begin
        pool_cd--;
        if (pool_cd == 0) i_pool_done = 1;
      end
    end else begin
      if (in_pool) begin in_pool = 0; hold_left = hold_extra; end
      if (hold_left > 0) hold_left--;
      else if (hold_left == 0) begin
        hold_left = -1;
        if (i_pool_done) begin i_pool_done = 0; pdlow_cyc = cyc; end
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %0d expected 0", o_busy); else n_pass++;
    n_total++; if (o_cal_wait !== 2'b00) $display("FAIL rst_cal_wait: got %0d expected 0", o_cal_wait); else n_pass++;
    n_total++; if (o_map_idx !== 3'd0) $display("FAIL rst_map_idx: got %0d expected 0", o_map_idx); else n_pass++;
    @(negedge clk); i_rst_n = 1;
    repeat (2) @(negedge clk);
    n_total++; if (o_conv_start !== 1'b0) $display("FAIL idle_conv_start: got %0d expected 0", o_conv_start); else n_pass++;
    n_total++; if (o_layer_done !== 1'b0) $display("FAIL idle_layer_done: got %0d expected 0", o_layer_done); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL idle_err: got %0d expected 0", o_err); else n_pass++;
  endtask

  task automatic test_full_layer();
    hold_extra = 0;
    kick();
    for (int i = 0; i < 500 && n_ld == 0; i++) resp_cycle();
    resp_cycle();
    n_total++; if (n_cs != 6) $display("FAIL l1_conv_starts: got %0d expected 6", n_cs); else n_pass++;
    n_total++; if (idx_bad != 0) $display("FAIL l1_map_idx_seq: got %0d bad expected 0", idx_bad); else n_pass++;
    n_total++; if (first_cs_cyc != 1) $display("FAIL l1_start_latency: got %0d expected 1", first_cs_cyc); else n_pass++;
    n_total++; if (lat_bad != 0) $display("FAIL l1_conv_to_pool_latency: got %0d bad expected 0", lat_bad); else n_pass++;
    n_total++; if (min_gap != 4 || max_gap != 4) $display("FAIL l1_drain_gap: got %0d..%0d expected 4", min_gap, max_gap); else n_pass++;
    n_total++; if (n_ld != 1) $display("FAIL l1_layer_done_count: got %0d expected 1", n_ld); else n_pass++;
    n_total++; if (ld_cyc != 337) $display("FAIL l1_layer_done_cycle: got %0d expected 337", ld_cyc); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL l1_busy_after: got %0d expected 0", o_busy); else n_pass++;
    n_total++; if (o_map_idx !== 3'd0) $display("FAIL l1_map_after: got %0d expected 0", o_map_idx); else n_pass++;
  endtask

  task automatic test_drain_extend();
    hold_extra = 6;
    kick();
    for (int i = 0; i < 500 && n_ld == 0; i++) resp_cycle();
    n_total++; if (min_gap != 7 || max_gap != 7) $display("FAIL l2_drain_gap: got %0d..%0d expected 7", min_gap, max_gap); else n_pass++;
    n_total++; if (last_delta != 1) $display("FAIL l2_pool_low_to_conv_start: got %0d expected 1", last_delta); else n_pass++;
    n_total++; if (ld_cyc != 355) $display("FAIL l2_layer_done_cycle: got %0d expected 355", ld_cyc); else n_pass++;
    hold_extra = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stale_pool();
    kick();
    @(negedge clk); i_start = 0;
    n_total++; if (o_conv_start !== 1'b1) $display("FAIL st_conv_start: got %0d expected 1", o_conv_start); else n_pass++;
    i_pool_done = 1; i_conv_done = 1;
    @(negedge clk); i_conv_done = 0;
    n_total++; if (o_cal_wait !== 2'b01) $display("FAIL st_conv_wait: got %0d expected 1", o_cal_wait); else n_pass++;
    @(negedge clk);
    n_total++; if (o_cal_wait !== 2'b11) $display("FAIL st_early_conv_done: got %0d expected 3", o_cal_wait); else n_pass++;
    repeat (5) @(negedge clk);
    n_total++; if (o_cal_wait !== 2'b11) $display("FAIL st_stale_hold: got %0d expected 3", o_cal_wait); else n_pass++;
    i_pool_done = 0;
    @(negedge clk);
    n_total++; if (o_cal_wait !== 2'b11) $display("FAIL st_low_seen: got %0d expected 3", o_cal_wait); else n_pass++;
    i_pool_done = 1;
    @(negedge clk);
    n_total++; if (o_cal_wait !== 2'b00) $display("FAIL st_fresh_accept: got %0d expected 0", o_cal_wait); else n_pass++;
    i_pool_done = 0; i_abort = 1;
    @(negedge clk); i_abort = 0;
    n_total++; if (o_busy !== 1'b0) $display("FAIL st_abort_idle: got %0d expected 0", o_busy); else n_pass++;
  endtask

  task automatic test_abort();
    bit found = 0;
    int ld_seen = 0;
    int busy_seen = 0;
    hold_extra = 0;
    kick();
    for (int i = 0; i < 500 && !found; i++) begin
      resp_cycle();
      if (o_map_idx === 3'd3 && o_cal_wait === 2'b11) found = 1;
    end
    n_total++; if (!found) $display("FAIL ab_reach_pool3: got 0 expected 1"); else n_pass++;
    i_abort = 1; i_start = 1;
    @(negedge clk); i_abort = 0; i_start = 0;
    n_total++; if (o_cal_wait !== 2'b00) $display("FAIL ab_cal_wait: got %0d expected 0", o_cal_wait); else n_pass++;
    n_total++; if (o_map_idx !== 3'd0) $display("FAIL ab_map_idx: got %0d expected 0", o_map_idx); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL ab_busy: got %0d expected 0", o_busy); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (o_layer_done === 1'b1) ld_seen++;
      if (o_busy === 1'b1) busy_seen++;
      @(negedge clk);
    end
    n_total++; if (ld_seen != 0 || busy_seen != 0) $display("FAIL ab_stays_idle: got ld=%0d busy=%0d expected 0", ld_seen, busy_seen); else n_pass++;
  endtask

  task automatic test_async_reset();
    bit found = 0;
    kick();
    for (int i = 0; i < 500 && !found; i++) begin
      resp_cycle();
      if (o_map_idx === 3'd2 && o_cal_wait === 2'b01 && o_conv_start === 1'b0) found = 1;
    end
    n_total++; if (!found) $display("FAIL rs_reach_map2: got 0 expected 1"); else n_pass++;
    #2 i_rst_n = 0;
    #1;
    n_total++;
    if ({o_conv_start, o_cal_wait, o_map_idx, o_busy, o_layer_done, o_err} !== 9'd0)
      $display("FAIL rs_async_zero: got %0h expected 0",
               {o_conv_start, o_cal_wait, o_map_idx, o_busy, o_layer_done, o_err});
    else n_pass++;
    resp_clear();
    @(negedge clk); i_rst_n = 1;
    kick();
    @(negedge clk); i_start = 0;
    n_total++; if (o_conv_start !== 1'b1 || o_map_idx !== 3'd0) $display("FAIL rs_restart: got cs=%0d idx=%0d expected 1/0", o_conv_start, o_map_idx); else n_pass++;
    i_abort = 1;
    @(negedge clk); i_abort = 0;
  endtask

`ifdef POOL_SCHED_TIMEOUT_EN
  task automatic test_watchdog();
    kick();
    @(negedge clk); i_start = 0;
    repeat (64) @(negedge clk);
    n_total++; if (o_err !== 1'b0 || o_cal_wait !== 2'b01) $display("FAIL wd_before: got err=%0d cw=%0d expected 0/1", o_err, o_cal_wait); else n_pass++;
    @(negedge clk);
    n_total++; if (o_err !== 1'b1 || o_cal_wait !== 2'b00 || o_busy !== 1'b1) $display("FAIL wd_trip: got err=%0d cw=%0d busy=%0d expected 1/0/1", o_err, o_cal_wait, o_busy); else n_pass++;
    repeat (4) @(negedge clk);
    n_total++; if (o_err !== 1'b1) $display("FAIL wd_sticky: got %0d expected 1", o_err); else n_pass++;
    i_abort = 1;
    @(negedge clk); i_abort = 0;
    n_total++; if (o_err !== 1'b0 || o_busy !== 1'b0) $display("FAIL wd_abort_clear: got err=%0d busy=%0d expected 0/0", o_err, o_busy); else n_pass++;
    kick();
    @(negedge clk); i_start = 0;
    repeat (65) @(negedge clk);
    i_start = 1;
    @(negedge clk);
    n_total++; if (o_err !== 1'b0 || o_busy !== 1'b0) $display("FAIL wd_start_clear: got err=%0d busy=%0d expected 0/0", o_err, o_busy); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (o_busy !== 1'b0) $display("FAIL wd_needs_fresh_start: got %0d expected 0", o_busy); else n_pass++;
    i_start = 0;
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
    n_total++; if (o_conv_start !== 1'b1) $display("FAIL wd_fresh_start: got %0d expected 1", o_conv_start); else n_pass++;
    i_abort = 1;
    @(negedge clk); i_abort = 0;
  endtask
`else
  task automatic test_watchdog();
    kick();
    @(negedge clk); i_start = 0;
    repeat (100) @(negedge clk);
    n_total++; if (o_err !== 1'b0) $display("FAIL wd_off_err: got %0d expected 0", o_err); else n_pass++;
    n_total++; if (o_cal_wait !== 2'b01 || o_busy !== 1'b1) $display("FAIL wd_off_waiting: got cw=%0d busy=%0d expected 1/1", o_cal_wait, o_busy); else n_pass++;
    i_abort = 1;
    @(negedge clk); i_abort = 0;
    n_total++; if (o_busy !== 1'b0) $display("FAIL wd_off_abort: got %0d expected 0", o_busy); else n_pass++;
  endtask
`endif

  initial begin
    resp_clear();
    hold_extra = 0;
    test_reset();
    test_full_layer();
    test_drain_extend();
    test_stale_pool();
    test_abort();
    test_async_reset();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
